// File: rtl/cam_pkg.sv
// Shared types and helpers for the camera frame-buffer writer.
// Holds the FSM state encoding, the RGB444 pack function and default image size.
package cam_pkg;

    localparam int IMG_W_DEFAULT = 160;
    localparam int IMG_H_DEFAULT = 120;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_WAIT_VS = ST_WAIT_VS,
        S_ACTIVE  = ST_ACTIVE,
        S_DONE    = ST_DONE
    } cam_state_t;

    // Input layout is R=[7:0], G=[15:8], B=[23:16]; keep the top nibble of each.
    function automatic logic [11:0] pack_rgb444(input logic [23:0] px);
        return {px[7:4], px[15:12], px[23:20]};
    endfunction

endpackage

// File: rtl/cam_fb_addr_gen.sv
// Raster x/y/address counters with window check and line skip for the frame buffer.
// FB_DECIMATE_EN: when defined, only even-x/even-y pixels are written to a half-size buffer.
module cam_fb_addr_gen
    import cam_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT,
    parameter int AW    = 15
) (
    input  logic          p_clock,
    input  logic          rst,
    input  logic          clear,
    input  logic          pixel_valid,
    input  logic          line_end,
    output logic          accept,
    output logic          drop,
    output logic [AW-1:0] addr
);

    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LIM = XW'(IMG_W);
    localparam logic [YW-1:0] Y_LIM = YW'(IMG_H);
`ifdef FB_DECIMATE_EN
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W / 2);
`else
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
`endif

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] base_reg;
    logic          in_window;
    logic          keep;
    logic          row_step_en;

    // Window is judged on full-resolution counts even when decimating.
    assign in_window = (x_reg < X_LIM) && (y_reg < Y_LIM);

`ifdef FB_DECIMATE_EN
    assign keep        = ~x_reg[0] & ~y_reg[0];
    assign row_step_en = y_reg[0];
`else
    assign keep        = 1'b1;
    assign row_step_en = 1'b1;
`endif

    assign accept = pixel_valid & in_window & keep;
    assign drop   = pixel_valid & ~in_window;
    assign addr   = addr_reg;

    always_ff @(posedge p_clock) begin
        if (rst || clear) begin
            x_reg    <= '0;
            y_reg    <= '0;
            addr_reg <= '0;
            base_reg <= '0;
        end else if (line_end) begin
            x_reg <= '0;
            // y saturates at the window edge so extra lines never wrap back in.
            if (y_reg < Y_LIM) begin
                y_reg <= y_reg + 1'b1;
                if (row_step_en) begin
                    base_reg <= base_reg + ROW_STEP;
                    addr_reg <= base_reg + ROW_STEP;
                end else begin
                    addr_reg <= base_reg;
                end
            end
        end else if (pixel_valid && in_window) begin
            x_reg <= x_reg + 1'b1;
            if (keep) begin
                addr_reg <= addr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_fb_writer.sv
// Camera pixel stream to RGB444 frame-buffer writer with frame sequencing FSM.
// FB_DECIMATE_EN (see cam_fb_addr_gen) selects the half-resolution buffer layout.
module cam_fb_writer
    import cam_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT,
    parameter int AW    = 15,
    parameter int DW    = 12
) (
    input  logic          p_clock,
    input  logic          rst,
    input  logic          enable,
    input  logic          vsync,
    input  logic          href,
    input  logic          pixel_valid,
    input  logic [23:0]   pixel_data,
    input  logic          frame_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          frame_ready,
    output logic          busy,
    output logic          overflow
);

    cam_state_t    state_reg, state_next;
    logic          vsync_reg;
    logic          href_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_data_reg;
    logic          overflow_reg;

    logic          vs_fall, vs_rise;
    logic          frame_start;
    logic          in_active;
    logic          accept, drop;
    logic [AW-1:0] pix_addr;

    assign vs_fall   = vsync_reg & ~vsync;
    assign vs_rise   = ~vsync_reg & vsync;
    assign in_active = (state_reg == S_ACTIVE) && enable;

    always_comb begin
        state_next  = state_reg;
        frame_start = 1'b0;
        if (!enable) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:    state_next = S_WAIT_VS;
                S_WAIT_VS: begin
                    if (vs_fall) begin
                        frame_start = 1'b1;
                        state_next  = S_ACTIVE;
                    end
                end
                S_ACTIVE:  if (vs_rise || frame_done) state_next = S_DONE;
                S_DONE:    state_next = S_WAIT_VS;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge p_clock) begin
        if (rst) begin
            state_reg <= S_IDLE;
            vsync_reg <= 1'b0;
            href_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            vsync_reg <= vsync;
            href_reg  <= href;
        end
    end

    cam_fb_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_addr_gen (
        .p_clock     (p_clock),
        .rst         (rst),
        .clear       (frame_start),
        .pixel_valid (pixel_valid & in_active),
        .line_end    (href_reg & ~href & in_active),
        .accept      (accept),
        .drop        (drop),
        .addr        (pix_addr)
    );

    // A pixel arriving with the closing vsync edge is still written here.
    always_ff @(posedge p_clock) begin
        if (rst) begin
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            mem_we_reg <= accept;
            if (accept) begin
                mem_addr_reg <= pix_addr;
                mem_data_reg <= DW'(pack_rgb444(pixel_data));
            end
            if (frame_start) begin
                overflow_reg <= 1'b0;
            end else if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_data    = mem_data_reg;
    assign overflow    = overflow_reg;
    assign busy        = (state_reg == S_ACTIVE);
    assign frame_ready = (state_reg == S_DONE) && enable;

endmodule

// File: tb/tb_cam_fb_writer.sv
// Randomized frame-level bench for cam_fb_writer against a raster-coordinate scoreboard.
`timescale 1ns/1ps
module tb_cam_fb_writer;

`ifdef FB_DECIMATE_EN
    localparam int W = 4;
    localparam int H = 4;
`else
    localparam int W = 4;
    localparam int H = 3;
`endif
    localparam int AW = 15;
    localparam int DW = 12;

    logic          p_clock = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [23:0]   pixel_data = '0;
    logic          frame_done = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          frame_ready;
    logic          busy;
    logic          overflow;

    cam_fb_writer #(.IMG_W(W), .IMG_H(H), .AW(AW), .DW(DW)) dut (
        .p_clock     (p_clock),
        .rst         (rst),
        .enable      (enable),
        .vsync       (vsync),
        .href        (href),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .frame_done  (frame_done),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .frame_ready (frame_ready),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 p_clock = ~p_clock;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  fr_count = 0;
    int  fr_cyc = 0;
    bit  ov_exp;
    int  n_wr;

    always @(posedge p_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    // Write monitor: every strobe must match the oldest predicted write.
    always @(negedge p_clock) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("stray_we", {17'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {17'd0, mem_addr}, mon_e.addr);
                check("wr_data", {20'd0, mem_data}, mon_e.data);
                check("wr_lat", cyc, mon_e.cyc);
            end
        end
        if (frame_ready === 1'b1) begin
            fr_count++;
            fr_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge p_clock);
        #1;
    endtask

    function automatic int pack_ref(input logic [23:0] d);
        int r, g, b;
        r = d[7:0];
        g = d[15:8];
        b = d[23:16];
        return (r / 16) * 256 + (g / 16) * 16 + (b / 16);
    endfunction

    function automatic bit kept(input int x, input int y);
`ifdef FB_DECIMATE_EN
        return (x % 2 == 0) && (y % 2 == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int addr_ref(input int x, input int y);
`ifdef FB_DECIMATE_EN
        return (y / 2) * (W / 2) + x / 2;
`else
        return y * W + x;
`endif
    endfunction

    task automatic drive_pixel(input int x, input int y, input bit use_fix, input logic [23:0] fix);
        wr_t e;
        pixel_data  = use_fix ? fix : 24'($urandom);
        pixel_valid = 1'b1;
        if (x >= W || y >= H) begin
            ov_exp = 1'b1;
        end else if (kept(x, y)) begin
            e.addr = addr_ref(x, y);
            e.data = pack_ref(pixel_data);
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
            n_wr++;
        end
        tick();
        pixel_valid = 1'b0;
    endtask

    // mode: 0 = vsync rise after last line, 1 = frame_done, 2 = vsync rise with last pixel.
    // abort_at >= 0 aborts before that pixel index (by enable drop, or by reset if abort_rst).
    task automatic run_frame(input int lens[8], input int nl, input int mode,
                             input int abort_at, input bit abort_rst,
                             input bit use_fix, input logic [23:0] fix);
        int start_fr, c_close, px_count;
        start_fr = fr_count;
        px_count = 0;
        ov_exp   = 1'b0;
        n_wr     = 0;
        enable   = 1'b1;
        href     = 1'b0;
        vsync    = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
        @(negedge p_clock);
        check("start_busy", busy, 1);
        check("start_ovf", overflow, 0);
        tick();
        c_close = 0;
        for (int y = 0; y < nl; y++) begin
            href = 1'b1;
            tick();
            for (int x = 0; x < lens[y]; x++) begin
                repeat ($urandom_range(0, 1)) tick();
                if (abort_at >= 0 && px_count == abort_at) begin
                    if (abort_rst) rst = 1'b1;
                    else enable = 1'b0;
                    pixel_valid = 1'b1;
                    pixel_data  = 24'($urandom);
                    tick();
                    pixel_valid = 1'b0;
                    @(negedge p_clock);
                    check("abort_we", mem_we, 0);
                    check("abort_busy", busy, 0);
                    if (abort_rst) begin
                        check("rst_addr", {17'd0, mem_addr}, 0);
                        check("rst_ovf", overflow, 0);
                    end
                    rst = 1'b0;
                    repeat (4) tick();
                    check("abort_frdy", fr_count - start_fr, 0);
                    check("abort_pend", exp_q.size(), 0);
                    $display("frame abort: rst=%0b after %0d pixels, writes=%0d", abort_rst, px_count, n_wr);
                    href = 1'b0;
                    return;
                end
                if (mode == 2 && y == nl - 1 && x == lens[y] - 1) begin
                    vsync   = 1'b1;
                    c_close = cyc;
                end
                drive_pixel(x, y, use_fix, fix);
                px_count++;
            end
            if (!(mode == 2 && y == nl - 1)) begin
                href = 1'b0;
                repeat (2) tick();
            end
        end
        if (mode == 0) begin
            vsync   = 1'b1;
            c_close = cyc;
            tick();
        end else if (mode == 1) begin
            frame_done = 1'b1;
            c_close    = cyc;
            tick();
            frame_done = 1'b0;
        end
        repeat (3) tick();
        check("frdy_count", fr_count - start_fr, 1);
        check("frdy_cyc", fr_cyc, c_close + 1);
        check("end_ovf", overflow, ov_exp);
        check("end_busy", busy, 0);
        check("pending", exp_q.size(), 0);
        $display("frame: lines=%0d mode=%0d writes=%0d ovf=%0b", nl, mode, n_wr, ov_exp);
    endtask

    initial begin
        int lens[8];
        rst = 1'b1;
        repeat (3) tick();
        @(negedge p_clock);
        check("rst_we", mem_we, 0);
        check("rst_addr0", {17'd0, mem_addr}, 0);
        check("rst_data", {20'd0, mem_data}, 0);
        check("rst_frdy", frame_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf0", overflow, 0);
        rst = 1'b0;
        tick();

        run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, H, 0, -1, 0, 1, 24'h0000FF);
        run_frame('{2, 4, 4, 4, 0, 0, 0, 0}, H, 0, -1, 0, 0, 24'h0);
        run_frame('{6, 4, 4, 4, 0, 0, 0, 0}, H, 1, -1, 0, 0, 24'h0);
        run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, H, 2, -1, 0, 0, 24'h0);
        run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, H, 0, 5, 0, 0, 24'h0);
        run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, H, 0, -1, 0, 0, 24'h0);
        run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, H, 1, 3, 1, 0, 24'h0);
        run_frame('{4, 4, 4, 4, 0, 0, 0, 0}, H, 1, -1, 0, 0, 24'h0);

        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 8; k++) lens[k] = $urandom_range(1, 6);
            run_frame(lens, $urandom_range(1, 5), $urandom_range(0, 2), -1, 0, 0, 24'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
